dmem_arbiter: RTL

- Shares the single-port 16-bit data memory (256 words, word-aligned, combinational read, synchronous write) between NUM_REQ requesters, e.g. the CPU load/store unit and the debug/loader port.
- Requesters use a valid/ready request and response handshake; the arbiter grants one requester at a time, round-robin.
- It sequences exactly one memory access per grant and returns a registered response.
- Misaligned or out-of-range addresses are rejected with an error response and never reach the memory.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_arbiter_rr.sv | 31 +++
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Also used by the instruction-fetch side.
package dmem_pkg;

    localparam int DMEM_DW = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_e;

    typedef struct packed {
        logic               we;
        logic [DMEM_DW-1:0] addr;
        logic [DMEM_DW-1:0] wdata;
    } dmem_req_t;

    // Word-aligned and inside 0 .. 2*depth-2.
    function automatic logic addr_legal(
        input logic [DMEM_DW-1:0] addr,
        input int unsigned        depth
    );
        logic [31:0] a;
        a = 32'(addr);
        return !a[0] && (a < 32'(2 * depth));
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Combinational round-robin arbiter.
// The scan starts just after the last winner.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 1; k <= N; k++) begin
            pos = IDX_W'((int'(last) + k) % N);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter in front of the single-port data memory.
// One access per grant, registered response.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 256,
    parameter int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0]                 req_we,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    input  logic [NUM_REQ-1:0]                 rsp_ready,
    output logic [DATA_WIDTH-1:0]              rsp_rdata,
    output logic                               rsp_err,
    output logic [DATA_WIDTH-1:0]              mem_access_addr,
    output logic [DATA_WIDTH-1:0]              mem_write_data,
    output logic                               mem_write_en,
    output logic                               mem_read,
    input  logic [DATA_WIDTH-1:0]              mem_read_data,
    output logic                               busy
);

    arb_state_e            state_q;
    arb_state_e            state_d;
    logic [IDX_W-1:0]      grant_q;
    logic [IDX_W-1:0]      last_q;
    logic [IDX_W-1:0]      win_idx;
    logic [NUM_REQ-1:0]    win_gnt;
    dmem_req_t             req_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  legal;
    logic                  hs;
    logic                  done;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req  (req_valid),
        .last (last_q),
        .gnt  (win_gnt),
        .idx  (win_idx)
    );

    assign legal = addr_legal(req_q.addr, MEM_DEPTH);
    assign hs    = (state_q == IDLE) && (|req_valid);
    assign done  = rsp_ready[grant_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        req_ready       = '0;
        rsp_valid       = '0;
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = win_gnt;
                if (hs) state_d = ACCESS;
            end
            ACCESS: begin
                // Illegal addresses never reach the memory.
                if (legal) begin
                    mem_access_addr = req_q.addr;
                    mem_write_data  = req_q.wdata;
                    mem_write_en    = req_q.we;
                    mem_read        = !req_q.we;
                end
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (hs) begin
                grant_q     <= win_idx;
                last_q      <= win_idx;
                req_q.we    <= req_we[win_idx];
                req_q.addr  <= req_addr[win_idx];
                req_q.wdata <= req_wdata[win_idx];
            end
            if (state_q == ACCESS) begin
                err_q   <= !legal;
                rdata_q <= (legal && !req_q.we) ? mem_read_data : '0;
            end
        end
    end

    assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    assign rsp_err   = (state_q == RESP) ? err_q : 1'b0;
    assign busy      = (state_q != IDLE);

endmodule
